instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage that drives the decode stage's instruction inputs (instruction, PC, PC+4, valid) and consumes its Alt_PC/Request_Alt_PC redirect and WANT_FREEZE outputs. It issues one outstanding word request at a time to the instruction memory/I-cache over a valid/ready request and valid-only response handshake. It buffers at most one returned word while decode is frozen and discards wrong-path responses after a redirect.

Parameters:
RESET_PC, 32'hBFC00000, fetch address loaded on reset.

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset
Alt_PC_IN  input  32  redirect target from decode
Request_Alt_PC_IN  input  1  redirect strobe from decode
WANT_FREEZE_IN  input  1  decode freeze request
IMem_Req_Addr  output  32  word address of fetch request
IMem_Req_Valid  output  1  request valid
IMem_Req_Ready  input  1  memory accepts request this cycle
IMem_Resp_Data  input  32  returned instruction word
IMem_Resp_Valid  input  1  response valid; one per accepted request, no backpressure
Instr1_OUT  output  32  instruction to decode
Instr_PC_OUT  output  32  PC of Instr1_OUT
Instr_PC_Plus4_OUT  output  32  Instr_PC_OUT+4
Instr1_Valid_OUT  output  1  Instr1_OUT is a new valid instruction

Behaviour:
- Reset (RESET=0, asynchronous): state=ISSUE, fetch_pc=RESET_PC, inflight_pc=0, squash=0, buffer empty. Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT and Instr1_Valid_OUT are all 0. IMem_Req_Valid is forced 0 while RESET=0.
- Internal registers: fetch_pc (next address), inflight_pc, squash, buf_data/buf_pc.
- Redirect: Alt_PC_IN[1:0] is ignored and treated as 00. Redirect has priority over every other event in every state.
- State ISSUE:
  - IMem_Req_Valid = !WANT_FREEZE_IN && !Request_Alt_PC_IN. IMem_Req_Addr = fetch_pc.
  - On Valid&&Ready: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32), go to WAIT.
  - On Request_Alt_PC_IN: fetch_pc<=Alt_PC_IN, stay in ISSUE; no request is issued that cycle.
- State WAIT:
  - IMem_Req_Valid=0.
  - On Request_Alt_PC_IN: fetch_pc<=Alt_PC_IN and squash<=1. If a response arrives in the same cycle, it is discarded and the state goes to ISSUE with squash<=0.
  - On IMem_Resp_Valid:
    - squash=1: drop the word, squash<=0, go to ISSUE.
    - Else, WANT_FREEZE_IN=0: Instr1_OUT<=data, Instr_PC_OUT<=inflight_pc, Instr_PC_Plus4_OUT<=inflight_pc+4, Instr1_Valid_OUT<=1, go to ISSUE.
    - Else (frozen): buf<=data/inflight_pc, go to FULL.
- State FULL:
  - IMem_Req_Valid=0.
  - On Request_Alt_PC_IN: the buffer is discarded, fetch_pc<=Alt_PC_IN, go to ISSUE.
  - Else, when WANT_FREEZE_IN=0: load the outputs from the buffer, Valid_OUT<=1, go to ISSUE.
- Output holding:
  - While WANT_FREEZE_IN=1, all four decode outputs hold their values, so decode sees the same instruction.
  - In any unfrozen cycle with no delivery, Instr1_Valid_OUT<=0 (bubble); the other outputs hold.
  - Redirect does not clear the currently presented instruction; it is the branch delay slot.
- Latency and throughput: a response in cycle t appears on the outputs at edge t. With memory latency L, the next request issues at t+1, giving one instruction per L+1 cycles.
- IMem_Resp_Valid outside WAIT is ignored. This covers stale responses after a mid-operation reset.
- At most one request is outstanding at any time.

Test Plan:
- Reset release, Ready=1, 2-cycle response latency, data=32'h24080001 → IMem_Req_Addr=BFC00000 first cycle; outputs become Instr=24080001, PC=BFC00000, PC+4=BFC00004, Valid=1; next request at BFC00004.
- Ready held 0 for 3 cycles → Req_Valid stays 1 with a stable address, no Valid_OUT pulses; request issues when Ready=1.
- Redirect to 32'h00400103 while in WAIT for BFC00008 → that response is dropped (Valid_OUT=0); next request address is 00400100.
- Freeze asserted before a response of 32'h0000000C → the word is buffered and the outputs hold the previous instruction for the whole freeze; one cycle after release the outputs show 0000000C with Valid=1; no request issues during the freeze.
- Redirect during FULL → the buffered word is never presented; next request is at Alt_PC.
- fetch_pc=FFFFFFFC fetched → Instr_PC_Plus4_OUT=00000000 and next request address 00000000; RESET pulsed low during WAIT → outputs 0 immediately, the late response is ignored, next request is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding I-memory request, a single-entry
// hold buffer for decode freezes, and squashing of wrong-path responses.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Alt_PC_IN,
   input  logic        Request_Alt_PC_IN,
   input  logic        WANT_FREEZE_IN,
   output logic [31:0] IMem_Req_Addr,
   output logic        IMem_Req_Valid,
   input  logic        IMem_Req_Ready,
   input  logic [31:0] IMem_Resp_Data,
   input  logic        IMem_Resp_Valid,
   output logic [31:0] Instr1_OUT,
   output logic [31:0] Instr_PC_OUT,
   output logic [31:0] Instr_PC_Plus4_OUT,
   output logic        Instr1_Valid_OUT
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        squash_q, squash_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] alt_pc;
   logic        req_valid;

   assign alt_pc    = Alt_PC_IN & 32'hFFFF_FFFC;
   assign req_valid = RESET && (state_q == ISSUE) && !WANT_FREEZE_IN && !Request_Alt_PC_IN;

   assign IMem_Req_Valid     = req_valid;
   assign IMem_Req_Addr      = fetch_pc_q;
   assign Instr1_OUT         = instr_q;
   assign Instr_PC_OUT       = pc_q;
   assign Instr_PC_Plus4_OUT = pc4_q;
   assign Instr1_Valid_OUT   = valid_q;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      squash_d      = squash_q;
      buf_data_d    = buf_data_q;
      buf_pc_d      = buf_pc_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      pc4_d         = pc4_q;
      valid_d       = valid_q;

      // An unfrozen cycle without a delivery presents a bubble.
      if (!WANT_FREEZE_IN) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ISSUE: begin
            if (Request_Alt_PC_IN) begin
               fetch_pc_d = alt_pc;
            end else if (req_valid && IMem_Req_Ready) begin
               inflight_pc_d = fetch_pc_q;
               fetch_pc_d    = fetch_pc_q + 32'd4;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            if (Request_Alt_PC_IN) begin
               fetch_pc_d = alt_pc;
               if (IMem_Resp_Valid) begin
                  squash_d = 1'b0;
                  state_d  = ISSUE;
               end else begin
                  squash_d = 1'b1;
               end
            end else if (IMem_Resp_Valid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = ISSUE;
               end else if (!WANT_FREEZE_IN) begin
                  instr_d = IMem_Resp_Data;
                  pc_d    = inflight_pc_q;
                  pc4_d   = inflight_pc_q + 32'd4;
                  valid_d = 1'b1;
                  state_d = ISSUE;
               end else begin
                  buf_data_d = IMem_Resp_Data;
                  buf_pc_d   = inflight_pc_q;
                  state_d    = FULL;
               end
            end
         end
         FULL: begin
            if (Request_Alt_PC_IN) begin
               fetch_pc_d = alt_pc;
               state_d    = ISSUE;
            end else if (!WANT_FREEZE_IN) begin
               instr_d = buf_data_q;
               pc_d    = buf_pc_q;
               pc4_d   = buf_pc_q + 32'd4;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         default: begin
            state_d = ISSUE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= ISSUE;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= 32'd0;
         squash_q      <= 1'b0;
         buf_data_q    <= 32'd0;
         buf_pc_q      <= 32'd0;
         instr_q       <= 32'd0;
         pc_q          <= 32'd0;
         pc4_q         <= 32'd0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         squash_q      <= squash_d;
         buf_data_q    <= buf_data_d;
         buf_pc_q      <= buf_pc_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         pc4_q         <= pc4_d;
         valid_q       <= valid_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, latency, ready stalls, redirects,
// freeze buffering, address wrap and mid-flight reset.
module tb_instr_fetch_unit;

   logic        CLK;
   logic        RESET;
   logic [31:0] Alt_PC_IN;
   logic        Request_Alt_PC_IN;
   logic        WANT_FREEZE_IN;
   logic [31:0] IMem_Req_Addr;
   logic        IMem_Req_Valid;
   logic        IMem_Req_Ready;
   logic [31:0] IMem_Resp_Data;
   logic        IMem_Resp_Valid;
   logic [31:0] Instr1_OUT;
   logic [31:0] Instr_PC_OUT;
   logic [31:0] Instr_PC_Plus4_OUT;
   logic        Instr1_Valid_OUT;

   int total;
   int bad;

   instr_fetch_unit #(.RESET_PC(32'hBFC00000)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .Alt_PC_IN         (Alt_PC_IN),
      .Request_Alt_PC_IN (Request_Alt_PC_IN),
      .WANT_FREEZE_IN    (WANT_FREEZE_IN),
      .IMem_Req_Addr     (IMem_Req_Addr),
      .IMem_Req_Valid    (IMem_Req_Valid),
      .IMem_Req_Ready    (IMem_Req_Ready),
      .IMem_Resp_Data    (IMem_Resp_Data),
      .IMem_Resp_Valid   (IMem_Resp_Valid),
      .Instr1_OUT        (Instr1_OUT),
      .Instr_PC_OUT      (Instr_PC_OUT),
      .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
      .Instr1_Valid_OUT  (Instr1_Valid_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic freeze, input logic redirect, input logic [31:0] alt,
                                input logic ready, input logic resp_valid, input logic [31:0] resp_data);
      WANT_FREEZE_IN    = freeze;
      Request_Alt_PC_IN = redirect;
      Alt_PC_IN         = alt;
      IMem_Req_Ready    = ready;
      IMem_Resp_Valid   = resp_valid;
      IMem_Resp_Data    = resp_data;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Checks the full decode-facing output set in one call.
   task automatic checkDecode(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic valid);
      checkOutput({tag, ".instr"}, Instr1_OUT, instr);
      checkOutput({tag, ".pc"}, Instr_PC_OUT, pc);
      checkOutput({tag, ".pc4"}, Instr_PC_Plus4_OUT, pc4);
      checkOutput({tag, ".valid"}, {31'd0, Instr1_Valid_OUT}, {31'd0, valid});
   endtask

   task automatic checkReq(input string tag, input logic valid, input logic [31:0] addr);
      checkOutput({tag, ".req_valid"}, {31'd0, IMem_Req_Valid}, {31'd0, valid});
      if (valid) begin
         checkOutput({tag, ".req_addr"}, IMem_Req_Addr, addr);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      RESET = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      tick();
      #1;
      checkDecode("reset", 32'd0, 32'd0, 32'd0, 1'b0);
      checkReq("reset", 1'b0, 32'd0);

      // First fetch with two-cycle response latency.
      RESET = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkReq("first_req", 1'b1, 32'hBFC00000);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkReq("wait1", 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h24080001);
      checkDecode("pre_deliver", 32'd0, 32'd0, 32'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkDecode("deliver1", 32'h24080001, 32'hBFC00000, 32'hBFC00004, 1'b1);
      checkReq("next_req", 1'b1, 32'hBFC00004);

      // Memory not ready for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
         checkReq("stall", 1'b1, 32'hBFC00004);
         checkOutput("stall.valid", {31'd0, Instr1_Valid_OUT}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h11111111);
      checkReq("stall_accepted", 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("deliver2", 32'h11111111, 32'hBFC00004, 32'hBFC00008, 1'b1);
      checkReq("req3", 1'b1, 32'hBFC00008);
      tick();

      // Redirect while waiting on BFC00008: its response must be dropped.
      applyStimulus(1'b0, 1'b1, 32'h00400103, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hDEADBEEF);
      checkDecode("redir_slot", 32'h11111111, 32'hBFC00004, 32'hBFC00008, 1'b0);
      checkReq("redir_wait", 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("squashed", 32'h11111111, 32'hBFC00004, 32'hBFC00008, 1'b0);
      checkReq("redir_target", 1'b1, 32'h00400100);

      // Deliver at 00400100, then hold it under a one-cycle freeze.
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h22222222);
      tick();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("deliver3", 32'h22222222, 32'h00400100, 32'h00400104, 1'b1);
      checkReq("freeze_noreq", 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("freeze_hold", 32'h22222222, 32'h00400100, 32'h00400104, 1'b1);
      checkReq("unfreeze_req", 1'b1, 32'h00400104);

      // Freeze before the response: word goes to the buffer.
      tick();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000000C);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
         checkDecode("buffered", 32'h22222222, 32'h00400100, 32'h00400104, 1'b0);
         checkReq("buffered", 1'b0, 32'd0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("from_buf", 32'h0000000C, 32'h00400104, 32'h00400108, 1'b1);
      checkReq("after_buf", 1'b1, 32'h00400108);

      // Buffer a word, then redirect while FULL: word never presented.
      tick();
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h33333333);
      tick();
      applyStimulus(1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkDecode("full_redir", 32'h0000000C, 32'h00400104, 32'h00400108, 1'b0);
      checkReq("full_redir", 1'b1, 32'hFFFFFFFC);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkDecode("buf_discarded", 32'h0000000C, 32'h00400104, 32'h00400108, 1'b0);

      // Fetch at FFFFFFFC wraps the next address to zero.
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h44444444);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkDecode("wrap", 32'h44444444, 32'hFFFFFFFC, 32'h00000000, 1'b1);
      checkReq("wrap", 1'b1, 32'h00000000);
      tick();

      // Reset mid-flight; the late response must be ignored.
      RESET = 1'b0;
      #1;
      checkDecode("async_reset", 32'd0, 32'd0, 32'd0, 1'b0);
      checkReq("async_reset", 1'b0, 32'd0);
      tick();
      RESET = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h55555555);
      checkReq("post_reset", 1'b1, 32'hBFC00000);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkDecode("stale_resp", 32'd0, 32'd0, 32'd0, 1'b0);
      checkReq("stale_resp", 1'b1, 32'hBFC00000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
